nor_gate: RTL and testbench

NOR_GATE -- requirements
Module: nor_gate

---
 rtl/nor_gate.sv | 78 +++++++
 tb/tb_nor_gate.sv | 120 ++++++++++++
 2 files changed

// File: rtl/nor_gate.sv
// Bitwise NOR of two WIDTH-bit operands with a one-cycle registered result, valid and zero flags.
// Define NOR_GATE_COMB_EN to build a purely combinational variant (valid tied high, clock unused).
module nor_gate #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic             valid,
    output logic             zero
);

    function automatic logic [WIDTH-1:0] nor_f(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        return ~(x | y);
    endfunction

    function automatic logic all_zero_f(input logic [WIDTH-1:0] x);
        return (x == {WIDTH{1'b0}});
    endfunction

    logic [WIDTH-1:0] nor_s;
    logic             nor_zero_s;

    // Result and its zero flag computed from the live operands.
    always_comb begin
        nor_s      = nor_f(a, b);
        nor_zero_s = all_zero_f(nor_s);
    end

`ifdef NOR_GATE_COMB_EN

    // Clock, reset and enable are deliberately ignored in this variant.
    logic unused_s;
    assign unused_s = clk ^ rst ^ en;

    // Pass the combinational result straight to the outputs.
    always_comb begin
        c     = nor_s;
        zero  = nor_zero_s;
        valid = 1'b1;
    end

`else

    logic [WIDTH-1:0] c_r;
    logic             valid_r;
    logic             zero_r;

    // Capture register: reset beats enable; idle cycles hold the data but drop valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_r     <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
            zero_r  <= 1'b0;
        end else if (en) begin
            c_r     <= nor_s;
            valid_r <= 1'b1;
            zero_r  <= nor_zero_s;
        end else begin
            c_r     <= c_r;
            valid_r <= 1'b0;
            zero_r  <= zero_r;
        end
    end

    // Outputs come directly from the registers.
    always_comb begin
        c     = c_r;
        valid = valid_r;
        zero  = zero_r;
    end

`endif

endmodule

// File: tb/tb_nor_gate.sv
// Directed self-checking bench for nor_gate (WIDTH=32); covers the combinational
// variant when compiled with NOR_GATE_COMB_EN.
module tb_nor_gate;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        valid;
    logic        zero;

    int checks;
    int errors;

    nor_gate #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .a     (a),
        .b     (b),
        .c     (c),
        .valid (valid),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive inputs, let one rising edge happen, then return at the next falling edge.
    task automatic cycle(input logic r, input logic e, input logic [31:0] av, input logic [31:0] bv);
        rst = r;
        en  = e;
        a   = av;
        b   = bv;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input logic [31:0] ec, input logic ev, input logic ez);
        check_val({tag, ".c"}, c, ec);
        check_val({tag, ".valid"}, {31'd0, valid}, {31'd0, ev});
        check_val({tag, ".zero"}, {31'd0, zero}, {31'd0, ez});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        en  = 1'b0;
        a   = 32'h0000_0000;
        b   = 32'h0000_0000;
`ifdef NOR_GATE_COMB_EN
        a = 32'h0000_0000; b = 32'h007F_A509; #1;
        expect_out("comb_mixed", 32'hFF80_5AF6, 1'b1, 1'b0);
        a = 32'h0000_0000; b = 32'h0000_0000; #1;
        expect_out("comb_zeros", 32'hFFFF_FFFF, 1'b1, 1'b0);
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; #1;
        expect_out("comb_ones", 32'h0000_0000, 1'b1, 1'b1);
        a = 32'hAAAA_5555; b = 32'h0F0F_0F0F; #1;
        expect_out("comb_pat", 32'h5050_A0A0, 1'b1, 1'b0);
`else
        @(negedge clk);
        cycle(1'b1, 1'b0, 32'h1234_5678, 32'h0000_0000);
        expect_out("reset", 32'h0000_0000, 1'b0, 1'b0);

        cycle(1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000);
        expect_out("nor00", 32'hFFFF_FFFF, 1'b1, 1'b0);

        cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000);
        expect_out("a_ones", 32'h0000_0000, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF);
        expect_out("b_ones", 32'h0000_0000, 1'b1, 1'b1);

        cycle(1'b0, 1'b1, 32'h0000_0000, 32'h007F_A509);
        expect_out("mixed", 32'hFF80_5AF6, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        expect_out("both_ones", 32'h0000_0000, 1'b1, 1'b1);

        cycle(1'b0, 1'b1, 32'h0000_0000, 32'h007F_A509);
        expect_out("reload", 32'hFF80_5AF6, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000);
        expect_out("hold1", 32'hFF80_5AF6, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        expect_out("hold2", 32'hFF80_5AF6, 1'b0, 1'b0);

        // Operand changes between edges must not reach the outputs.
        en = 1'b1; a = 32'h0000_0000; b = 32'h0000_0000; #2;
        expect_out("no_edge", 32'hFF80_5AF6, 1'b0, 1'b0);

        cycle(1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000);
        expect_out("rst_over_en", 32'h0000_0000, 1'b0, 1'b0);

        cycle(1'b0, 1'b0, 32'hAAAA_5555, 32'h0F0F_0F0F);
        expect_out("post_rst_idle", 32'h0000_0000, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'hAAAA_5555, 32'h0F0F_0F0F);
        expect_out("post_rst_first", 32'h5050_A0A0, 1'b1, 1'b0);

        cycle(1'b0, 1'b1, 32'h0000_0001, 32'h0000_0000);
        expect_out("stream", 32'hFFFF_FFFE, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000);
        expect_out("stream_rst", 32'h0000_0000, 1'b0, 1'b0);

        cycle(1'b0, 1'b1, 32'h8000_0000, 32'h0000_0001);
        expect_out("edges", 32'h7FFF_FFFE, 1'b1, 1'b0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
